// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART byte serializer among N requesters.
// Optional build macro UART_SCHED_PRIO0_EN: requester 0 becomes strict priority.
module uart_tx_sched #(
  parameter int N          = 4,
  parameter int GAP_CYCLES = 8,
  parameter int START_TO   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   ack,
  output logic [7:0]     tx_data,
  output logic           tx_start,
  input  logic           tx_busy,
  output logic [2:0]     grant_id,
  output logic           sched_idle,
  output logic           start_err
);
  localparam int CMAX = (GAP_CYCLES > START_TO) ? GAP_CYCLES : START_TO;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = $clog2(N);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAITB, BUSY, GAP} state_t;
  state_t state, stateNxt;

  logic [PW-1:0] rrPtr, rrNxt, selId, idx;
  logic [N-1:0]  reqElig;
  logic [CW-1:0] cnt;
  logic          selHit, prioHit;

  // Rotating scan starting at rrPtr; first eligible requester wins.
  always_comb begin
    reqElig = req;
    selHit  = 1'b0;
    selId   = '0;
    idx     = '0;
`ifdef UART_SCHED_PRIO0_EN
    prioHit    = req[0];
    selHit     = req[0];
    reqElig[0] = 1'b0;
`else
    prioHit = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(rrPtr) + i) % N);
      if (!selHit && reqElig[idx]) begin
        selHit = 1'b1;
        selId  = idx;
      end
    end
  end

  assign rrNxt      = (selId == PW'(N - 1)) ? '0 : selId + PW'(1);
  assign sched_idle = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:   if (selHit) stateNxt = LAUNCH;
      LAUNCH: stateNxt = WAITB;
      WAITB:  if (tx_busy) stateNxt = BUSY;
              else if (cnt == CW'(START_TO - 1)) stateNxt = GAP;
      BUSY:   if (!tx_busy) stateNxt = GAP;
      GAP:    if (cnt == '0) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // One counter serves both the start timeout and the inter-frame gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack       <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      grant_id  <= '0;
      start_err <= 1'b0;
      rrPtr     <= '0;
      cnt       <= '0;
    end else begin
      ack      <= '0;
      tx_start <= (state == LAUNCH);
      case (state)
        IDLE: if (selHit) begin
          ack      <= N'(1) << selId;
          tx_data  <= req_data[{selId, 3'b000} +: 8];
          grant_id <= 3'(selId);
          if (!prioHit) rrPtr <= rrNxt;
        end
        LAUNCH: cnt <= '0;
        WAITB: if (!tx_busy) begin
          if (cnt == CW'(START_TO - 1)) begin
            start_err <= 1'b1;
            cnt       <= CW'(GAP_CYCLES);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BUSY: if (!tx_busy) cnt <= CW'(GAP_CYCLES);
        GAP:  if (cnt != '0) cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end
endmodule
